// File: rtl/edge_row_packer.sv
// edge_row_packer: binarises an 8-bit edge-magnitude raster stream and packs each
// row into one WIDTH-bit word. Words are queued in a small FIFO behind ready/valid.
// Also reports a per-frame set-bit count, a frame-done pulse and a sticky overflow flag.
module edge_row_packer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [7:0]       thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_row,
  output logic             frame_done,
  output logic [10:0]      edge_count,
  output logic             overflow
);

  localparam int unsigned COLW = $clog2(WIDTH);
  localparam int unsigned ROWW = $clog2(HEIGHT);
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = 11;

  logic [COLW-1:0]  col_q, col_d;
  logic [ROWW-1:0]  row_q, row_d;
  logic [7:0]       thresh_q, thresh_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [CNTW-1:0]  run_q, run_d;
  logic [CNTW-1:0]  edge_count_q, edge_count_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;
  logic [PTRW:0]    wr_q, wr_d;
  logic [PTRW:0]    rd_q, rd_d;
  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_d [DEPTH];
  logic [4:0]       row_mem_q  [DEPTH];
  logic [4:0]       row_mem_d  [DEPTH];

  logic             first_pix;
  logic [7:0]       thr;
  logic             pix_bit;
  logic             last_col;
  logic             last_row;
  logic [WIDTH-1:0] word;
  logic [PTRW:0]    count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;

  // Pixel counters, threshold latch, row assembly, frame count and FIFO update
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    thresh_d     = thresh_q;
    asm_d        = asm_q;
    run_d        = run_q;
    edge_count_d = edge_count_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    data_mem_d   = data_mem_q;
    row_mem_d    = row_mem_q;

    // Until the first pixel of a frame is taken the threshold tracks the live input
    first_pix = (col_q == '0) && (row_q == '0);
    thr       = first_pix ? thresh : thresh_q;
    pix_bit   = in_data > thr;
    last_col  = col_q == COLW'(WIDTH - 1);
    last_row  = row_q == ROWW'(HEIGHT - 1);
    word      = asm_q | (WIDTH'(pix_bit) << col_q);

    count = wr_q - rd_q;
    empty = count == '0;
    full  = count == (PTRW + 1)'(DEPTH);
    pop   = !empty && out_ready;
    push  = in_valid && last_col;

    if (first_pix) thresh_d = thresh;

    if (in_valid) begin
      col_d = last_col ? '0 : col_q + COLW'(1);
      if (last_col) row_d = last_row ? '0 : row_q + ROWW'(1);
      asm_d = last_col ? '0 : word;
      run_d = run_q + CNTW'(pix_bit);
      if (last_col && last_row) begin
        edge_count_d = run_q + CNTW'(pix_bit);
        run_d        = '0;
        frame_done_d = 1'b1;
      end
    end

    if (pop) rd_d = rd_q + (PTRW + 1)'(1);

    // A full FIFO still accepts the word when the head leaves on the same edge
    if (push) begin
      if (!full || pop) begin
        data_mem_d[wr_q[PTRW-1:0]] = word;
        row_mem_d[wr_q[PTRW-1:0]]  = 5'(row_q);
        wr_d = wr_q + (PTRW + 1)'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      thresh_q     <= '0;
      asm_q        <= '0;
      run_q        <= '0;
      edge_count_q <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem_q[i] <= '0;
        row_mem_q[i]  <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      thresh_q     <= thresh_d;
      asm_q        <= asm_d;
      run_q        <= run_d;
      edge_count_q <= edge_count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      data_mem_q   <= data_mem_d;
      row_mem_q    <= row_mem_d;
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : data_mem_q[rd_q[PTRW-1:0]];
  assign out_row    = empty ? '0 : row_mem_q[rd_q[PTRW-1:0]];
  assign frame_done = frame_done_q;
  assign edge_count = edge_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_edge_row_packer.sv
// Bench for edge_row_packer: a pixel-index/queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_edge_row_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [7:0]  thresh = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_row;
  logic        frame_done;
  logic [10:0] edge_count;
  logic        overflow;

  edge_row_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .frame_done(frame_done), .edge_count(edge_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  row;
    logic [31:0] word;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  int          m_pix;
  logic [7:0]  m_fthr;
  logic [31:0] m_asm;
  int          m_frame;
  int          m_ec;
  logic        m_fd;
  logic        m_ovf;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pix = 0; m_fthr = '0; m_asm = '0; m_frame = 0; m_ec = 0; m_fd = 1'b0; m_ovf = 1'b0;
  endtask

  // Next state from the inputs that the coming rising edge will see
  task automatic model_step();
    int   c;
    int   r;
    logic b;
    logic pop;
    logic full;
    logic do_push;
    ent_t ent;
    pop     = (mq.size() != 0) && out_ready;
    full    = mq.size() == 4;
    do_push = 1'b0;
    ent     = '0;
    m_fd    = 1'b0;
    if (in_valid) begin
      c = m_pix % 32;
      r = m_pix / 32;
      if (m_pix == 0) m_fthr = thresh;
      b = in_data > m_fthr;
      if (b) m_asm[c] = 1'b1;
      m_frame += int'(b);
      if (c == 31) begin
        do_push  = 1'b1;
        ent.row  = 5'(r);
        ent.word = m_asm;
        m_asm    = '0;
      end
      if (m_pix == 1023) begin
        m_ec    = m_frame;
        m_frame = 0;
        m_fd    = 1'b1;
      end
      m_pix = (m_pix + 1) % 1024;
    end
    if (pop) void'(mq.pop_front());
    if (do_push) begin
      if (!full || pop) mq.push_back(ent);
      else m_ovf = 1'b1;
    end
  endtask

  // Compare every DUT output against the model
  task automatic compare();
    logic ev;
    ev = mq.size() != 0;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", out_data, ev ? mq[0].word : 32'h0);
    chk("out_row", 32'(out_row), ev ? 32'(mq[0].row) : 32'h0);
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("edge_count", 32'(edge_count), 32'(m_ec));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (frame_done) fd_seen++;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [7:0] t, input logic r);
    @(negedge clk);
    compare();
    in_valid  = v;
    in_data   = d;
    thresh    = t;
    out_ready = r;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_row", 32'(out_row), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_edge_count", 32'(edge_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset mid-row, then a clean all-ones row
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'd255, 8'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1'b1, 8'd255, 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    chk("lit_ones_word", out_data, 32'hFFFF_FFFF);
    chk("lit_ones_row", 32'(out_row), 32'h0);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);

    // Alternating pattern
    do_reset();
    for (int c = 0; c < 32; c++) cycle(1'b1, (c % 2 == 0) ? 8'd255 : 8'd0, 8'd100, 1'b1);
    cycle(1'b0, 8'd0, 8'd100, 1'b1);
    chk("lit_pattern_word", out_data, 32'h5555_5555);
    chk("lit_pattern_valid", 32'(out_valid), 32'h1);
    cycle(1'b0, 8'd0, 8'd100, 1'b1);
    chk("lit_pattern_gone", 32'(out_valid), 32'h0);

    // Threshold equality and frame-locked threshold
    do_reset();
    for (int c = 0; c < 32; c++)
      cycle(1'b1, (c == 0) ? 8'd100 : (c == 1) ? 8'd101 : 8'd0, 8'd100, 1'b0);
    cycle(1'b0, 8'd0, 8'd100, 1'b0);
    chk("lit_boundary_word", out_data, 32'h0000_0002);
    for (int c = 0; c < 32; c++) cycle(1'b1, 8'd50, 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    chk("lit_locked_row", 32'(out_row), 32'h1);
    chk("lit_locked_word", out_data, 32'h0);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);

    // Full frame with random gaps
    do_reset();
    fd_seen = 0;
    for (int i = 0; i < 1024; i++) begin
      while ($urandom % 4 == 0) cycle(1'b0, 8'($urandom), 8'd0, 1'b1);
      cycle(1'b1, 8'd255, 8'd0, 1'b1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1);
    chk("lit_frame_pulses", 32'(fd_seen), 32'h1);
    chk("lit_frame_count", 32'(edge_count), 32'd1024);
    chk("lit_frame_ovf", 32'(overflow), 32'h0);

    // Backpressure: row 4 dropped
    do_reset();
    for (int i = 0; i < 5 * 32; i++) cycle(1'b1, 8'($urandom), 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    chk("lit_bp_ovf", 32'(overflow), 32'h1);
    chk("lit_bp_head", 32'(out_row), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'd0, 8'd0, 1'b1);
      chk("lit_bp_drain_row", 32'(out_row), 32'(i));
    end
    for (int i = 0; i < 32; i++) cycle(1'b1, 8'($urandom), 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    chk("lit_bp_next_row", 32'(out_row), 32'd5);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);

    // Full FIFO with a pop on the pushing edge
    do_reset();
    for (int i = 0; i < 4 * 32 + 31; i++) cycle(1'b1, 8'($urandom), 8'd0, 1'b0);
    cycle(1'b1, 8'($urandom), 8'd0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 8'd0, 8'd0, 1'b1);
      chk("lit_fp_row", 32'(out_row), 32'(i));
    end
    chk("lit_fp_ovf", 32'(overflow), 32'h0);

    // Randomised traffic with occasional resets
    do_reset();
    begin
      logic [7:0] t;
      logic [7:0] d;
      t = 8'd128;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom % 1500 == 0) do_reset();
        if ($urandom % 64 == 0) t = 8'($urandom);
        d = ($urandom % 8 == 0) ? t : 8'($urandom);
        cycle(($urandom % 4) != 0, d, t, ($urandom % 3) != 0);
      end
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_row_packer.md
# edge_row_packer

Downstream consumer of the Sobel edge stage. It takes the 8-bit edge-magnitude stream (one `in_valid` beat per pixel, raster order, 32×32 frame) and binarises each pixel against a programmable threshold. It packs each 32-pixel row into one 32-bit word and buffers the words in a small FIFO behind a ready/valid output. It also reports a per-frame edge-pixel count and a frame-done pulse. The upstream stage has no backpressure, so buffer exhaustion is flagged rather than stalled.

## Interface
- `WIDTH`, 32, pixels per row; equals the output word width.
- `HEIGHT`, 32, rows per frame.
- `DEPTH`, 4, FIFO entries (row words); power of two, ≥2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  pixel beat qualifier; gaps between beats and rows are arbitrary.
- `in_data`  in  8  edge magnitude, unsigned.
- `thresh`  in  8  binarisation threshold, unsigned.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head word.
- `out_data`  out  WIDTH  packed row; bit c = column c.
- `out_row`  out  5  row index of the head word.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `edge_count`  out  11  number of set bits in the last completed frame.
- `overflow`  out  1  sticky flag: a row word was dropped.

## Operation
- Counters: `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) advance only on `in_valid`. `col` wraps to 0 after WIDTH-1 and increments `row`. `row` wraps to 0 after HEIGHT-1, which starts a new frame.
- Threshold: `thresh_q` loads `thresh` every cycle while no pixel of the current frame has been accepted (col=0 and row=0). The first pixel of a frame compares against live `thresh`. All other pixels use `thresh_q`. This keeps `thresh` constant within a frame.
- Binarisation: bit = (in_data > threshold), strictly greater. A pixel equal to the threshold gives 0.
- Packing: a shift/assembly register collects the bits. On the beat with col=WIDTH-1, the completed word (including the current bit) and `row` are pushed into the FIFO at that clock edge. The assembly register then clears.
- FIFO:
  - Push and pop in the same cycle are legal in every occupancy state.
  - When full with a simultaneous pop, the push succeeds.
  - When full without a pop, the word is dropped and `overflow` is set. `overflow` stays set until `rst`. Counters still advance, so the next row keeps its true index.
  - Pop occurs when out_valid && out_ready.
- Outputs: `out_data` and `out_row` show the FIFO head and are forced to 0 when the FIFO is empty.
- Edge count: a running 11-bit count accumulates set bits over the frame. On the final pixel (row=HEIGHT-1, col=WIDTH-1), `edge_count` loads running count + current bit, and the running count clears. The maximum value is 1024, which fits in 11 bits. No saturation is needed.
- Reset mid-operation: all counters, the assembly register, FIFO pointers and flags clear. A partial row or frame is discarded, and the next `in_valid` is treated as row 0, col 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, frame_done=0, edge_count=0, overflow=0.
- Row latency: `out_valid` rises in the cycle after the edge that accepted pixel col=WIDTH-1, provided the FIFO was empty.
- `frame_done` is high for exactly one cycle, following the edge that accepted the last pixel of the frame. `edge_count` updates on that same edge.
- `overflow` rises in the cycle after the dropping edge.
- Throughput: one pixel per cycle in. Output drains one word per cycle while `out_ready` is held high.
- `out_valid` never deasserts without a pop. `out_data` is stable while out_valid && !out_ready.

## Test plan
- Reset: assert `rst` mid-row with 10 pixels accepted → all outputs 0. The next 32 pixels of value 255 with thresh=0 → word 0xFFFFFFFF, out_row=0.
- Pattern: thresh=100, one row with col c = 255 for even c and 0 for odd c, out_ready=1 → out_data=0x55555555, out_row=0, out_valid high for 1 cycle.
- Threshold boundary: thresh=100, col0=100, col1=101, the rest 0 → out_data=0x00000002. Changing `thresh` to 0 mid-frame does not affect row 1.
- Full frame: 1024 pixels of 255 with thresh=0, out_ready=1, random in_valid gaps → 32 words of 0xFFFFFFFF with out_row 0..31 in order, one `frame_done` pulse, edge_count=1024, overflow=0.
- Backpressure with DEPTH=4 and out_ready=0: rows 0-3 fill the FIFO and out_row stays 0. Row 4 is dropped and overflow=1. Raising out_ready then yields rows 0,1,2,3, and the next row delivered is 5.
- Full plus simultaneous pop: with the FIFO full, hold out_ready=1 on the edge where the last pixel of row 4 is accepted → no drop, overflow stays 0, and row 4 appears after rows 1-3.
